// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam int DIV_MIN = 2;

    // Number of clk cycles the positive phase lasts for divisor n.
    function automatic logic [31:0] half_period(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Divisor-configuration handshake between a requester and clk_div_ctrl.
interface clk_div_ctrl_if #(
    parameter int DIV_W = 8
) ();
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_duty.sv
// Output stage: registers the positive phase; with CLK_DIV_ODD_DUTY_EN defined a
// negedge flop stretches the high phase by half a cycle for odd divisors.
module clk_div_duty (
    input  logic clk,
    input  logic rst,
    input  logic clk_pos_n,
    input  logic odd,
    output logic clk_out
);
    logic clk_pos;

    always_ff @(posedge clk) begin
        if (rst) clk_pos <= 1'b0;
        else     clk_pos <= clk_pos_n;
    end

`ifdef CLK_DIV_ODD_DUTY_EN
    logic clk_neg;
    logic armed;

    always_ff @(negedge clk) begin
        if (rst) clk_neg <= 1'b0;
        else     clk_neg <= clk_pos;
    end

    // Masks the stale negedge copy for the half cycle right after a reset edge.
    always_ff @(posedge clk) begin
        armed <= ~rst;
    end

    assign clk_out = clk_pos | (clk_neg & odd & armed);
`else
    logic unused_odd;
    assign unused_odd = odd;
    assign clk_out    = clk_pos;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider controller (top). Optional odd-divisor
// 50% duty correction is enabled with macro CLK_DIV_ODD_DUTY_EN.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    clk_div_ctrl_if.slave    cfg,
    output logic             clk_out,
    output logic             running,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div
);
    localparam logic [DIV_W-1:0] DIV_MIN_W = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] DIV_DEF_W = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE_W     = DIV_W'(1);

    state_e           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] cur_div_n;
    logic [DIV_W-1:0] pend_div;
    logic             pend, pend_n;
    logic             wrap, accept, bad, clk_pos_n;

    always_comb begin
        wrap      = (state != ST_IDLE) && (cnt == cur_div - ONE_W);
        accept    = cfg.cfg_valid && !pend;
        bad       = accept && (cfg.cfg_div < DIV_MIN_W);
        state_n   = state;
        cnt_n     = cnt;
        cur_div_n = cur_div;
        pend_n    = pend;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (pend) begin
                    cur_div_n = pend_div;
                    pend_n    = 1'b0;
                end
                if (en) state_n = ST_RUN;
            end
            ST_RUN, ST_STOP: begin
                if (wrap) begin
                    // Period boundary: the only point where N may change or we may idle.
                    cnt_n = '0;
                    if (pend) begin
                        cur_div_n = pend_div;
                        pend_n    = 1'b0;
                    end
                    state_n = en ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_n   = cnt + ONE_W;
                    state_n = en ? ST_RUN : ST_STOP;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (accept && !bad) pend_n = 1'b1;

        clk_pos_n = (state_n != ST_IDLE) &&
                    (cnt_n < DIV_W'(half_period(32'(cur_div_n))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cur_div     <= DIV_DEF_W;
            pend        <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cur_div     <= cur_div_n;
            pend        <= pend_n;
            cfg.cfg_err <= bad;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !bad) pend_div <= cfg.cfg_div;
    end

    assign cfg.cfg_ready = !pend;
    assign running       = (state != ST_IDLE);
    assign tick          = wrap;

    clk_div_duty u_duty (
        .clk       (clk),
        .rst       (rst),
        .clk_pos_n (clk_pos_n),
        .odd       (cur_div[0]),
        .clk_out   (clk_out)
    );

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock divider controller. It divides `clk` by an integer N that can be changed while running, and produces a registered, glitch-free `clk_out`. Divisor changes and start/stop requests take effect only at output-period boundaries, so no runt pulses appear. It sequences the divide-by-N datapath for downstream blocks that need a programmable slow clock, and adds 50%-duty correction for odd divisors.

## Interface
Parameters:
- `DIV_W`, default 8: divisor width; legal N is 2..2^DIV_W-1.
- `DEFAULT_DIV`, default 3: active divisor after reset; must be at least 2.

Ports:
- `clk`, input, 1: the single clock. All flops use it; the duty flop uses its negedge.
- `rst`, input, 1: reset, synchronous and active-high.
- `en`, input, 1: run request (level).
- `cfg_valid`, input, 1: new-divisor request.
- `cfg_div`, input, DIV_W: requested divisor.
- `cfg_ready`, output, 1: high when no divisor change is pending.
- `cfg_err`, output, 1: one-cycle pulse when an accepted `cfg_div` is less than 2.
- `clk_out`, output, 1: divided clock.
- `running`, output, 1: high in RUN and STOP.
- `tick`, output, 1: one-cycle pulse on the last `clk` cycle of each output period.
- `cur_div`, output, DIV_W: active divisor.

## Operation
- State machine with states IDLE, RUN and STOP.
  - IDLE → RUN when `en`=1.
  - RUN → STOP when `en`=0.
  - STOP → RUN when `en`=1, with no break in the output.
  - STOP → IDLE at wrap (`cnt`==N-1).
- Counter `cnt` runs 0..N-1 in RUN/STOP and wraps to 0. It is held at 0 in IDLE.
- Positive-phase flop `clk_pos` = 1 while `cnt` < floor(N/2), registered from next-state values.
- Config handshake:
  - A request is accepted when `cfg_valid` & `cfg_ready`.
  - If `cfg_div` < 2: assert `cfg_err`, drop the request, leave `cfg_ready` high.
  - Otherwise latch the value into `pend_div` and drive `cfg_ready`=0.
  - In IDLE, `pend_div` is applied on the next edge.
  - In RUN/STOP, `pend_div` is applied at the wrap edge; the new period starts with `cnt`=0 under the new N.
  - `cfg_ready` returns to 1 on the edge where the new divisor is applied.
- `tick` = (RUN or STOP) & `cnt`==N-1.
- Reset values:
  - state IDLE, `cnt`=0, `cur_div`=`DEFAULT_DIV`.
  - `clk_out`=0, `clk_pos`=0, `clk_neg`=0.
  - `cfg_ready`=1, `cfg_err`=0, `running`=0, `tick`=0.
- Reset mid-period: `clk_out` goes low immediately after the reset edge, and any pending config is discarded.

## Timing
- Start latency: `en` sampled high in IDLE → `clk_out` rises at that same edge (registered). One period is N `clk` cycles.
- Even N: high N/2 cycles, low N/2.
- Stop: `clk_out` completes its current period; its last falling edge is no later than the wrap. `running` falls at the wrap edge.
- Boundary conditions:
  - Accept coinciding with a wrap edge: the new divisor applies at the *following* wrap.
  - `en` falling and a config apply in the same wrap: go to IDLE with the new `cur_div`.
  - A new request while one is pending is not accepted; the requester holds `cfg_valid`.
  - Writing N equal to the current `cur_div` is still a full handshake.

## Configuration
- Macro `CLK_DIV_ODD_DUTY_EN`.
  - **Defined:** a negedge flop `clk_neg` <= `clk_pos`, with `clk_out` = `clk_pos` | (`clk_neg` & N odd). Odd N gives N/2 cycles high, i.e. 50% duty. `clk_neg` also resets synchronously (on the negedge).
  - **Undefined:** `clk_out` = `clk_pos`. Odd N gives floor(N/2) cycles high and ceil(N/2) low. No negedge logic exists.

## Structure
- Package `clk_div_pkg` holds:
  - the state enum (IDLE, RUN, STOP);
  - `DIV_MIN`=2;
  - a helper function for half-period computation.
- Sub-module `clk_div_duty` holds the `clk_pos` → `clk_out` stage, including the macro-guarded negedge flop.

## Test plan
- **Reset defaults:** after reset, `en`=1 → `clk_out` period 3, 1.5 cycles high with macro / 1 high and 2 low without; `cur_div`=3.
- **Mid-run change:** in RUN at N=4, write `cfg_div`=6 at `cnt`=1 → `cfg_ready` low until wrap; the next period is 6 cycles with 3 high; no runt pulse.
- **Illegal divisor:** `cfg_div`=1 → `cfg_err` pulses one cycle, `cur_div` unchanged, `cfg_ready` stays 1. Same for 0.
- **Stop and restart:** at N=5, drop `en` at `cnt`=2 → output completes the period, IDLE after the wrap. Dropping and re-raising `en` within the same period gives a continuous output.
- **Simultaneous events:** accept at the wrap edge → applies one period later. Accept and stop at the same wrap → IDLE with the new divisor.
- **Reset mid-operation:** assert `rst` at `cnt`=3 with a config pending → `clk_out`=0, pending config discarded, `cur_div`=`DEFAULT_DIV`.
